// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch lap controller.
// The optional lap counter is enabled by defining STOPWATCH_LAP_COUNT_EN.
package stopwatch_pkg;

    localparam int unsigned TIME_W          = 5;
    localparam int unsigned CLK_DIV_DEFAULT = 100;

    typedef enum logic [3:0] {
        MODE_IDLE    = 4'b1000,
        MODE_RUNNING = 4'b0100,
        MODE_LAP     = 4'b0010,
        MODE_STOPPED = 4'b0001
    } mode_e;

    function automatic logic is_counting(input mode_e m);
        return (m == MODE_RUNNING) || (m == MODE_LAP);
    endfunction

endpackage

// File: rtl/button_edge.sv
// Two-flop synchronizer plus registered rising-edge detector for a raw button.
// A press first sampled at edge N produces a one-cycle edge_o pulse after edge N+2.
module button_edge (
    input  logic clk,
    input  logic rst_i,
    input  logic btn_i,
    output logic edge_o
);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic prev_q,  prev_d;
    logic edge_q,  edge_d;

    always_comb begin
        sync1_d = btn_i;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
        edge_d  = sync2_q & ~prev_q;
    end

    always_ff @(posedge clk) begin
        if (rst_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            edge_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
            edge_q  <= edge_d;
        end
    end

    assign edge_o = edge_q;

endmodule

// File: rtl/stopwatch_lap_ctrl.sv
// Stopwatch with start/stop and lap/clear buttons, 5-bit seconds display.
// Define STOPWATCH_LAP_COUNT_EN to add the saturating lap_cnt_o output.
module stopwatch_lap_ctrl
    import stopwatch_pkg::*;
#(
    parameter int unsigned CLK_DIV = CLK_DIV_DEFAULT
) (
    input  logic              clk,
    input  logic              Rst_i,
    input  logic              start_i,
    input  logic              lap_i,
    output logic [3:0]        mode,
    output logic [TIME_W-1:0] time_o,
`ifdef STOPWATCH_LAP_COUNT_EN
    output logic [2:0]        lap_cnt_o,
`endif
    output logic              tick_o
);

    localparam int unsigned PRESC_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(CLK_DIV - 1);

    logic start_edge;
    logic lap_edge;

    button_edge u_start_edge (
        .clk    (clk),
        .rst_i  (Rst_i),
        .btn_i  (start_i),
        .edge_o (start_edge)
    );

    button_edge u_lap_edge (
        .clk    (clk),
        .rst_i  (Rst_i),
        .btn_i  (lap_i),
        .edge_o (lap_edge)
    );

    mode_e               state_q, state_d;
    logic [PRESC_W-1:0]  presc_q, presc_d;
    logic [TIME_W-1:0]   count_q, count_d;
    logic [TIME_W-1:0]   lap_q,   lap_d;
    logic [TIME_W-1:0]   time_q,  time_d;
    logic                tick_q,  tick_d;
`ifdef STOPWATCH_LAP_COUNT_EN
    logic [2:0]          lap_cnt_q, lap_cnt_d;
`endif

    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        count_d = count_q;
        lap_d   = lap_q;
        tick_d  = 1'b0;
`ifdef STOPWATCH_LAP_COUNT_EN
        lap_cnt_d = lap_cnt_q;
`endif

        // Counting follows the current state, so a tick coinciding with a transition still lands.
        if (is_counting(state_q)) begin
            if (presc_q == PRESC_MAX) begin
                presc_d = '0;
                count_d = count_q + 1'b1;
                tick_d  = 1'b1;
            end else begin
                presc_d = presc_q + 1'b1;
            end
        end

        case (state_q)
            MODE_IDLE: begin
                presc_d = '0;
                count_d = '0;
                lap_d   = '0;
                if (start_edge) state_d = MODE_RUNNING;
            end
            MODE_RUNNING: begin
                if (start_edge) begin
                    state_d = MODE_STOPPED;
                end else if (lap_edge) begin
                    state_d = MODE_LAP;
                    lap_d   = count_q;
`ifdef STOPWATCH_LAP_COUNT_EN
                    if (lap_cnt_q != 3'd7) lap_cnt_d = lap_cnt_q + 3'd1;
`endif
                end
            end
            MODE_LAP: begin
                if (start_edge)    state_d = MODE_STOPPED;
                else if (lap_edge) state_d = MODE_RUNNING;
            end
            MODE_STOPPED: begin
                if (start_edge) begin
                    state_d = MODE_RUNNING;
                end else if (lap_edge) begin
                    state_d = MODE_IDLE;
                    presc_d = '0;
                    count_d = '0;
                    lap_d   = '0;
                end
            end
            default: state_d = MODE_IDLE;
        endcase

`ifdef STOPWATCH_LAP_COUNT_EN
        if (state_d == MODE_IDLE) lap_cnt_d = '0;
`endif

        time_d = (state_d == MODE_LAP) ? lap_d : count_d;
    end

    always_ff @(posedge clk) begin
        if (Rst_i) begin
            state_q <= MODE_IDLE;
            presc_q <= '0;
            count_q <= '0;
            lap_q   <= '0;
            time_q  <= '0;
            tick_q  <= 1'b0;
`ifdef STOPWATCH_LAP_COUNT_EN
            lap_cnt_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            count_q <= count_d;
            lap_q   <= lap_d;
            time_q  <= time_d;
            tick_q  <= tick_d;
`ifdef STOPWATCH_LAP_COUNT_EN
            lap_cnt_q <= lap_cnt_d;
`endif
        end
    end

    assign mode   = state_q;
    assign time_o = time_q;
    assign tick_o = tick_q;
`ifdef STOPWATCH_LAP_COUNT_EN
    assign lap_cnt_o = lap_cnt_q;
`endif

endmodule

// File: tb/tb_stopwatch_lap_ctrl.sv
// Directed self-checking bench for stopwatch_lap_ctrl (CLK_DIV reduced to 10).
// Define STOPWATCH_LAP_COUNT_EN to also exercise lap_cnt_o.
module tb_stopwatch_lap_ctrl;

    localparam int unsigned DIV = 10;
    localparam int unsigned M_IDLE    = 4'b1000;
    localparam int unsigned M_RUNNING = 4'b0100;
    localparam int unsigned M_LAP     = 4'b0010;
    localparam int unsigned M_STOPPED = 4'b0001;

    logic       clk = 1'b0;
    logic       Rst_i;
    logic       start_i;
    logic       lap_i;
    logic [3:0] mode;
    logic [4:0] time_o;
    logic       tick_o;
`ifdef STOPWATCH_LAP_COUNT_EN
    logic [2:0] lap_cnt_o;
`endif

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    always #5 clk = ~clk;

    stopwatch_lap_ctrl #(.CLK_DIV(DIV)) dut (
        .clk       (clk),
        .Rst_i     (Rst_i),
        .start_i   (start_i),
        .lap_i     (lap_i),
        .mode      (mode),
        .time_o    (time_o),
`ifdef STOPWATCH_LAP_COUNT_EN
        .lap_cnt_o (lap_cnt_o),
`endif
        .tick_o    (tick_o)
    );

    task automatic chk(input string tag, input int unsigned obs, input int unsigned exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        Rst_i   = 1'b1;
        start_i = 1'b0;
        lap_i   = 1'b0;
        step(2);
        Rst_i   = 1'b0;
    endtask

    // One-cycle press; returns just after the edge at which mode changes.
    task automatic press(input logic s, input logic l);
        start_i = s;
        lap_i   = l;
        step(1);
        start_i = 1'b0;
        lap_i   = 1'b0;
        step(3);
    endtask

    initial begin
        int unsigned ticks;
        int unsigned trans;
        logic [3:0]  prev;

        Rst_i   = 1'b1;
        start_i = 1'b0;
        lap_i   = 1'b0;

        // Reset state
        do_reset();
        chk("rst_mode", mode, M_IDLE);
        chk("rst_time", time_o, 0);
        chk("rst_tick", tick_o, 0);

        // Lap ignored in IDLE
        press(1'b0, 1'b1);
        chk("idle_lap_mode", mode, M_IDLE);
        chk("idle_lap_time", time_o, 0);

        // Run, 15.5 s, then wrap at 32 s
        do_reset();
        press(1'b1, 1'b0);
        chk("run_mode", mode, M_RUNNING);
        chk("run_time0", time_o, 0);
        step(DIV - 1);
        chk("run_pre_tick", time_o, 0);
        step(1);
        chk("run_first_inc", time_o, 1);
        chk("run_first_tick", tick_o, 1);
        step(14 * DIV + DIV / 2);
        chk("run_15p5", time_o, 15);
        chk("run_15p5_tick", tick_o, 0);
        step(16 * DIV + DIV / 2);
        chk("run_wrap", time_o, 0);
        chk("run_wrap_tick", tick_o, 1);

        // Lap display holds while counting continues
        do_reset();
        press(1'b1, 1'b0);
        step(10 * DIV);
        chk("lap_pre", time_o, 10);
        press(1'b0, 1'b1);
        chk("lap_mode", mode, M_LAP);
        chk("lap_time", time_o, 10);
        step(5 * DIV - 8);
        chk("lap_hold_time", time_o, 10);
        chk("lap_hold_mode", mode, M_LAP);
        press(1'b0, 1'b1);
        chk("lap_back_mode", mode, M_RUNNING);
        chk("lap_back_time", time_o, 15);

        // Stop, freeze, resume from frozen prescaler, then clear
        do_reset();
        press(1'b1, 1'b0);
        step(7 * DIV);
        press(1'b1, 1'b0);
        chk("stop_mode", mode, M_STOPPED);
        chk("stop_time", time_o, 7);
        ticks = 0;
        for (int i = 0; i < int'(3 * DIV); i++) begin
            step(1);
            if (tick_o) ticks++;
        end
        chk("stop_no_tick", ticks, 0);
        chk("stop_frozen", time_o, 7);
        press(1'b1, 1'b0);
        chk("resume_mode", mode, M_RUNNING);
        step(DIV - 5);
        chk("resume_pre_inc", time_o, 7);
        step(1);
        chk("resume_inc", time_o, 8);
        chk("resume_tick", tick_o, 1);
        step(4);
        chk("resume_1s", time_o, 8);
        press(1'b1, 1'b0);
        chk("stop2_mode", mode, M_STOPPED);
        press(1'b0, 1'b1);
        chk("clear_mode", mode, M_IDLE);
        chk("clear_time", time_o, 0);

        // Simultaneous start and lap: start wins
        do_reset();
        press(1'b1, 1'b0);
        press(1'b0, 1'b1);
        press(1'b0, 1'b1);
        chk("both_pre_mode", mode, M_RUNNING);
        step(3 * DIV - 8);
        chk("both_pre_time", time_o, 3);
        press(1'b1, 1'b1);
        chk("both_mode", mode, M_STOPPED);
        chk("both_time", time_o, 3);
`ifdef STOPWATCH_LAP_COUNT_EN
        chk("both_lapcnt", lap_cnt_o, 1);
`endif

        // Long hold gives one transition; reset mid-run
        do_reset();
        start_i = 1'b1;
        prev    = mode;
        trans   = 0;
        for (int i = 0; i < 20; i++) begin
            step(1);
            if (mode != prev) trans++;
            prev = mode;
        end
        start_i = 1'b0;
        chk("hold_trans", trans, 1);
        chk("hold_mode", mode, M_RUNNING);
        step(12 * DIV - 16);
        chk("hold_time12", time_o, 12);
        Rst_i = 1'b1;
        step(1);
        chk("midrst_mode", mode, M_IDLE);
        chk("midrst_time", time_o, 0);

        // Button held across reset release counts as a new press
        start_i = 1'b1;
        step(1);
        Rst_i = 1'b0;
        step(3);
        chk("held_rst_wait", mode, M_IDLE);
        step(1);
        chk("held_rst_run", mode, M_RUNNING);
        start_i = 1'b0;
        step(5);
        chk("held_rst_stay", mode, M_RUNNING);

`ifdef STOPWATCH_LAP_COUNT_EN
        // Lap counter saturates at 7 and clears in IDLE
        do_reset();
        press(1'b1, 1'b0);
        for (int i = 0; i < 9; i++) begin
            press(1'b0, 1'b1);
            press(1'b0, 1'b1);
        end
        chk("lapcnt_sat", lap_cnt_o, 7);
        press(1'b1, 1'b0);
        chk("lapcnt_stop_mode", mode, M_STOPPED);
        chk("lapcnt_stop", lap_cnt_o, 7);
        press(1'b0, 1'b1);
        chk("lapcnt_idle_mode", mode, M_IDLE);
        chk("lapcnt_clear", lap_cnt_o, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
